traffic_light_ctrl: RTL and testbench
=====================================

Name: traffic_light_ctrl

Overview:
- Parametrised two-direction intersection controller (north-south / east-west). Successor to the single-lamp green/yellow/red sequencer.
- Adds the following over that sequencer:
  - an internal tick divider generated from CLOCK_50;
  - independent NS and EW lamp groups, with all-red clearance phases;
  - a night flashing-yellow mode;
  - a remaining-seconds countdown for the 7-segment display path.
- Sits between the board clock/keys and the LED and 7-segment decoders.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 1, phase-timer tick rate. CLK_HZ/TICK_HZ must be an integer of at least 2.
- GREEN_S, 9, green duration in ticks.
- YELLOW_S, 3, yellow duration in ticks.
- ALLRED_S, 1, all-red clearance duration in ticks.
- PED_SHORT_S, 2, value NS green is truncated to on a pedestrian request. Used only with the optional feature.
- CNT_W, 5, countdown width. Every duration must be at least 1 and at most 2^CNT_W-1; elaboration error otherwise.

Ports:
- CLOCK_50  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- night_i  in  1  level request for night flashing mode.
- ped_req_i  in  1  pedestrian request pulse, synchronous to CLOCK_50.
- ns_lamp_o  out  3  NS lamps {red, yellow, green}, one-hot except in NIGHT.
- ew_lamp_o  out  3  EW lamps {red, yellow, green}.
- remain_o  out  CNT_W  ticks remaining in the current phase.
- state_o  out  3  current phase code.
- ped_walk_o  out  1  pedestrian walk indication.
- tick_o  out  1  one-cycle tick strobe, for debug and display blanking.

Behaviour:
- Reset is asynchronous and active-low.
  - State is ALL_RED_1, remain_o = ALLRED_S.
  - ns_lamp_o = ew_lamp_o = 3'b100.
  - ped_walk_o = 0, tick_o = 0.
  - Divider counter is cleared and the pedestrian latch is cleared.
- Tick divider:
  - Counter runs from 0 to CLK_HZ/TICK_HZ-1.
  - tick_o pulses high for one cycle when the counter wraps.
  - The first tick after reset release occurs CLK_HZ/TICK_HZ cycles after the first active edge.
- Phase order: ALL_RED_1(0) -> NS_GREEN(1) -> NS_YELLOW(2) -> ALL_RED_2(3) -> EW_GREEN(4) -> EW_YELLOW(5) -> ALL_RED_1. NIGHT is code 6.
- Phase timing:
  - On entry to a phase, remain is loaded with that phase's duration.
  - Each tick decrements remain.
  - On a tick with remain == 1, the next phase is entered and its duration loaded in the same edge.
  - Each phase therefore lasts exactly its duration in ticks, and remain_o shows DUR..1, never 0, outside NIGHT.
- Lamp outputs are registered and update on the same edge as the state register.
  - Green phase: green lamp for that direction, red for the other.
  - Yellow phase: yellow lamp for that direction, red for the other.
  - ALL_RED phases: red for both directions.
- Night entry:
  - night_i is sampled only on the tick that ends an ALL_RED phase.
  - If night_i is high there, the next state is NIGHT instead of the following green.
  - Green and yellow phases always run to completion, so NIGHT is never entered directly from green.
- NIGHT:
  - remain_o = 0.
  - Both lamp groups show yellow only; the yellow bit toggles on every tick and starts lit on entry.
  - On a tick with night_i low, go to ALL_RED_1 with remain = ALLRED_S, then continue the normal sequence to NS_GREEN.
- Simultaneous events: if night_i falls and a tick arrives in the same cycle, the tick uses the current night_i value.
- Reset mid-phase: immediate return to the reset state. No partial phase is resumed.

Optional Feature:
- Macro: TRAFFIC_PED_REQ_EN.
- With the macro defined:
  - A ped_req_i pulse sets a sticky latch.
  - While the latch is set in NS_GREEN with remain > PED_SHORT_S, remain is loaded with PED_SHORT_S on the next cycle.
  - If a tick arrives in that same cycle, the load takes priority and no decrement occurs.
  - The latch clears on entry to EW_GREEN.
  - ped_walk_o = 1 exactly while the state is EW_GREEN and the latch was set when that phase was entered.
  - A request arriving during NIGHT is held until the next NS_GREEN.
- Without the macro: ped_req_i is ignored and ped_walk_o is tied to 0. The port list is identical in both builds.

Decomposition:
- Package traffic_pkg holds:
  - the phase enum (3-bit codes above);
  - lamp encoding constants LAMP_RED = 3'b100, LAMP_YEL = 3'b010, LAMP_GRN = 3'b001, LAMP_OFF = 3'b000.
- Sub-module traffic_tick_gen (params CLK_HZ, TICK_HZ; ports CLOCK_50, rst_n, tick_o) implements the divider. The FSM stays in the top module.

Test Plan:
- Reset timing, with CLK_HZ=10 and TICK_HZ=1:
  - After release: lamps 100/100, remain_o=1, state_o=0.
  - First tick at cycle 10.
  - After that tick: state_o=1, ns_lamp_o=001, ew_lamp_o=100, remain_o=9.
- Full cycle:
  - Run 26 ticks from the start of NS_GREEN, checking remain_o sequences 9..1, 3..1, 1, 9..1, 3..1, 1.
  - The machine must be back at NS_GREEN with remain_o=9.
- Night mode:
  - Raise night_i mid NS_GREEN.
  - NS_YELLOW and ALL_RED_2 complete, then NIGHT is entered with both lamps 010, remain_o=0.
  - Lamps must be 000 on the next tick and 010 on the one after.
  - Drop night_i: next tick goes to ALL_RED_1, the tick after goes to NS_GREEN.
- Reset mid-operation:
  - Assert rst_n low mid EW_YELLOW, between clock edges.
  - Outputs go to 100/100 and remain_o=1 without a clock edge.
  - The first tick comes 10 cycles after release.
- Pedestrian request (TRAFFIC_PED_REQ_EN defined):
  - A ped_req_i pulse at NS_GREEN remain_o=7 gives remain_o=2 on the next cycle.
  - ped_walk_o=1 for all 9 EW_GREEN ticks, then 0.
  - A pulse at remain_o=1 must not alter timing.
- Pedestrian request (TRAFFIC_PED_REQ_EN undefined): the same stimulus leaves remain_o unchanged and ped_walk_o stays 0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared phase codes and lamp encodings for the intersection controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALL_RED_1 = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALL_RED_2 = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        NIGHT     = 3'd6
    } phase_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        n = ALL_RED_1;
        case (p)
            ALL_RED_1: n = NS_GREEN;
            NS_GREEN:  n = NS_YELLOW;
            NS_YELLOW: n = ALL_RED_2;
            ALL_RED_2: n = EW_GREEN;
            EW_GREEN:  n = EW_YELLOW;
            default:   n = ALL_RED_1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// Divides CLOCK_50 down to a registered one-cycle tick strobe.
module traffic_tick_gen #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    output logic tick_o
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
        $error("CLK_HZ/TICK_HZ must be an integer of at least 2");
    end

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(DIV - 1));

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            tick_o <= 1'b0;
        end else begin
            cnt    <= wrap ? '0 : cnt + 1'b1;
            tick_o <= wrap;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-direction intersection controller with night flashing mode.
// Pedestrian request shortening is enabled by defining TRAFFIC_PED_REQ_EN.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int TICK_HZ     = 1,
    parameter int GREEN_S     = 9,
    parameter int YELLOW_S    = 3,
    parameter int ALLRED_S    = 1,
    parameter int PED_SHORT_S = 2,
    parameter int CNT_W       = 5
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             night_i,
    input  logic             ped_req_i,
    output logic [2:0]       ns_lamp_o,
    output logic [2:0]       ew_lamp_o,
    output logic [CNT_W-1:0] remain_o,
    output logic [2:0]       state_o,
    output logic             ped_walk_o,
    output logic             tick_o
);

    localparam int MAX_D = (1 << CNT_W) - 1;

    if (GREEN_S < 1 || GREEN_S > MAX_D ||
        YELLOW_S < 1 || YELLOW_S > MAX_D ||
        ALLRED_S < 1 || ALLRED_S > MAX_D ||
        PED_SHORT_S < 1 || PED_SHORT_S > MAX_D) begin : g_bad_dur
        $error("phase durations must lie in 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] D_GRN = CNT_W'(GREEN_S);
    localparam logic [CNT_W-1:0] D_YEL = CNT_W'(YELLOW_S);
    localparam logic [CNT_W-1:0] D_AR  = CNT_W'(ALLRED_S);
    localparam logic [CNT_W-1:0] D_PED = CNT_W'(PED_SHORT_S);

    function automatic logic [CNT_W-1:0] dur(input phase_t p);
        logic [CNT_W-1:0] d;
        d = '0;
        case (p)
            ALL_RED_1, ALL_RED_2: d = D_AR;
            NS_GREEN, EW_GREEN:   d = D_GRN;
            NS_YELLOW, EW_YELLOW: d = D_YEL;
            default:              d = '0;
        endcase
        return d;
    endfunction

    phase_t           state, state_n;
    logic [CNT_W-1:0] remain, remain_n;
    logic [2:0]       ns_lamp, ns_n;
    logic [2:0]       ew_lamp, ew_n;
    logic             blink, blink_n;
    logic             latch, latch_n;
    logic             walk, walk_n;
    logic             tick;
    logic             req;
    logic             shorten;

    traffic_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick (
        .CLOCK_50(CLOCK_50),
        .rst_n   (rst_n),
        .tick_o  (tick)
    );

`ifdef TRAFFIC_PED_REQ_EN
    // A request in the current cycle counts as if already latched.
    assign req = latch | ped_req_i;
`else
    logic unused_ped;
    assign unused_ped = ped_req_i;
    assign req        = 1'b0;
`endif

    assign shorten = req && (state == NS_GREEN) && (remain > D_PED);

    always_comb begin
        state_n = state;
        remain_n = remain;
        blink_n = blink;
        latch_n = req;
        walk_n = walk;
        ns_n = LAMP_RED;
        ew_n = LAMP_RED;
        if (shorten) begin
            remain_n = D_PED;
        end else if (tick) begin
            if (state == NIGHT) begin
                if (!night_i) begin
                    state_n  = ALL_RED_1;
                    remain_n = D_AR;
                end else begin
                    blink_n = ~blink;
                end
            end else if (remain == 1) begin
                state_n = next_phase(state);
                if ((state == ALL_RED_1 || state == ALL_RED_2) && night_i)
                    state_n = NIGHT;
                remain_n = dur(state_n);
                blink_n  = 1'b1;
                walk_n   = (state_n == EW_GREEN) ? req : 1'b0;
                if (state_n == EW_GREEN)
                    latch_n = 1'b0;
            end else begin
                remain_n = remain - 1'b1;
            end
        end
        case (state_n)
            NS_GREEN:  ns_n = LAMP_GRN;
            NS_YELLOW: ns_n = LAMP_YEL;
            EW_GREEN:  ew_n = LAMP_GRN;
            EW_YELLOW: ew_n = LAMP_YEL;
            NIGHT: begin
                ns_n = blink_n ? LAMP_YEL : LAMP_OFF;
                ew_n = blink_n ? LAMP_YEL : LAMP_OFF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ALL_RED_1;
            remain  <= D_AR;
            ns_lamp <= LAMP_RED;
            ew_lamp <= LAMP_RED;
            blink   <= 1'b0;
            latch   <= 1'b0;
            walk    <= 1'b0;
        end else begin
            state   <= state_n;
            remain  <= remain_n;
            ns_lamp <= ns_n;
            ew_lamp <= ew_n;
            blink   <= blink_n;
            latch   <= latch_n;
            walk    <= walk_n;
        end
    end

    assign ns_lamp_o  = ns_lamp;
    assign ew_lamp_o  = ew_lamp;
    assign remain_o   = remain;
    assign state_o    = state;
    assign ped_walk_o = walk;
    assign tick_o     = tick;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed-vector bench for traffic_light_ctrl with a 10-cycle tick.
module tb_traffic_light_ctrl;

`ifdef TRAFFIC_PED_REQ_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       night;
    logic       ped_req;
    logic [2:0] ns_lamp;
    logic [2:0] ew_lamp;
    logic [4:0] remain;
    logic [2:0] state;
    logic       walk;
    logic       tick;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_light_ctrl #(
        .CLK_HZ (10),
        .TICK_HZ(1)
    ) dut (
        .CLOCK_50  (clk),
        .rst_n     (rst_n),
        .night_i   (night),
        .ped_req_i (ped_req),
        .ns_lamp_o (ns_lamp),
        .ew_lamp_o (ew_lamp),
        .remain_o  (remain),
        .state_o   (state),
        .ped_walk_o(walk),
        .tick_o    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait (bounded) for the tick strobe, then let the FSM consume it.
    task automatic next_tick();
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 15) begin
            step();
            n++;
        end
        if (tick !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: tick=%b after %0d cycles, required 1", tick, n);
        end
        step();
    endtask

    task automatic until_state(input logic [2:0] target);
        int n;
        n = 0;
        while (state !== target && n < 40) begin
            next_tick();
            n++;
        end
        n_checks++;
        if (state !== target) begin
            n_fail++;
            $display("FAIL state_timeout: state=%0d, required %0d", state, target);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        night   = 1'b0;
        ped_req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ns_lamp !== 3'b100 || ew_lamp !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_lamps: ns=%b ew=%b, required 100/100", ns_lamp, ew_lamp);
        end
        n_checks++;
        if (remain !== 5'd1 || state !== 3'd0 || walk !== 1'b0 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rem=%0d st=%0d walk=%b tick=%b, required 1/0/0/0",
                     remain, state, walk, tick);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            n_checks++;
            if (tick !== 1'b0 || state !== 3'd0 || remain !== 5'd1) begin
                n_fail++;
                $display("FAIL early_tick cycle %0d: tick=%b st=%0d rem=%0d, required 0/0/1",
                         i, tick, state, remain);
            end
        end
        step();
        n_checks++;
        if (tick !== 1'b1) begin
            n_fail++;
            $display("FAIL first_tick: tick=%b at cycle 10, required 1", tick);
        end
        step();
        n_checks++;
        if (state !== 3'd1 || ns_lamp !== 3'b001 || ew_lamp !== 3'b100 || remain !== 5'd9) begin
            n_fail++;
            $display("FAIL enter_ns_green: st=%0d ns=%b ew=%b rem=%0d, required 1/001/100/9",
                     state, ns_lamp, ew_lamp, remain);
        end
    endtask

    task automatic test_full_cycle();
        int exp_rem[26] = '{8, 7, 6, 5, 4, 3, 2, 1, 3, 2, 1, 1,
                            9, 8, 7, 6, 5, 4, 3, 2, 1, 3, 2, 1, 1, 9};
        int exp_st[26] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 3,
                           4, 4, 4, 4, 4, 4, 4, 4, 4, 5, 5, 5, 0, 1};
        logic [2:0] ens, eew;
        for (int k = 0; k < 26; k++) begin
            next_tick();
            ens = 3'b100;
            eew = 3'b100;
            case (exp_st[k])
                1: ens = 3'b001;
                2: ens = 3'b010;
                4: eew = 3'b001;
                5: eew = 3'b010;
                default: ;
            endcase
            n_checks++;
            if (state !== 3'(exp_st[k]) || remain !== 5'(exp_rem[k]) ||
                ns_lamp !== ens || ew_lamp !== eew) begin
                n_fail++;
                $display("FAIL cycle_tick %0d: st=%0d rem=%0d ns=%b ew=%b, required %0d/%0d/%b/%b",
                         k + 1, state, remain, ns_lamp, ew_lamp,
                         exp_st[k], exp_rem[k], ens, eew);
            end
        end
    endtask

    task automatic test_night();
        repeat (3) next_tick();
        night = 1'b1;
        repeat (6) next_tick();
        n_checks++;
        if (state !== 3'd2 || remain !== 5'd3) begin
            n_fail++;
            $display("FAIL night_yellow_runs: st=%0d rem=%0d, required 2/3", state, remain);
        end
        repeat (3) next_tick();
        n_checks++;
        if (state !== 3'd3 || ns_lamp !== 3'b100 || ew_lamp !== 3'b100) begin
            n_fail++;
            $display("FAIL night_allred2: st=%0d ns=%b ew=%b, required 3/100/100",
                     state, ns_lamp, ew_lamp);
        end
        next_tick();
        n_checks++;
        if (state !== 3'd6 || remain !== 5'd0 || ns_lamp !== 3'b010 || ew_lamp !== 3'b010) begin
            n_fail++;
            $display("FAIL night_entry: st=%0d rem=%0d ns=%b ew=%b, required 6/0/010/010",
                     state, remain, ns_lamp, ew_lamp);
        end
        next_tick();
        n_checks++;
        if (state !== 3'd6 || ns_lamp !== 3'b000 || ew_lamp !== 3'b000) begin
            n_fail++;
            $display("FAIL night_blink_off: st=%0d ns=%b ew=%b, required 6/000/000",
                     state, ns_lamp, ew_lamp);
        end
        next_tick();
        n_checks++;
        if (state !== 3'd6 || ns_lamp !== 3'b010 || ew_lamp !== 3'b010) begin
            n_fail++;
            $display("FAIL night_blink_on: st=%0d ns=%b ew=%b, required 6/010/010",
                     state, ns_lamp, ew_lamp);
        end
        night = 1'b0;
        next_tick();
        n_checks++;
        if (state !== 3'd0 || remain !== 5'd1 || ns_lamp !== 3'b100 || ew_lamp !== 3'b100) begin
            n_fail++;
            $display("FAIL night_exit: st=%0d rem=%0d ns=%b ew=%b, required 0/1/100/100",
                     state, remain, ns_lamp, ew_lamp);
        end
        next_tick();
        n_checks++;
        if (state !== 3'd1 || remain !== 5'd9) begin
            n_fail++;
            $display("FAIL night_resume: st=%0d rem=%0d, required 1/9", state, remain);
        end
    endtask

    task automatic test_reset_mid();
        repeat (23) next_tick();
        n_checks++;
        if (state !== 3'd5 || remain !== 5'd2) begin
            n_fail++;
            $display("FAIL reach_ew_yellow: st=%0d rem=%0d, required 5/2", state, remain);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ns_lamp !== 3'b100 || ew_lamp !== 3'b100 || remain !== 5'd1 ||
            state !== 3'd0 || walk !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: ns=%b ew=%b rem=%0d st=%0d walk=%b, required 100/100/1/0/0",
                     ns_lamp, ew_lamp, remain, state, walk);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            n_checks++;
            if (tick !== 1'b0 || state !== 3'd0) begin
                n_fail++;
                $display("FAIL rst_early_tick cycle %0d: tick=%b st=%0d, required 0/0",
                         i, tick, state);
            end
        end
        step();
        n_checks++;
        if (tick !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_first_tick: tick=%b at cycle 10, required 1", tick);
        end
        step();
        n_checks++;
        if (state !== 3'd1 || remain !== 5'd9) begin
            n_fail++;
            $display("FAIL rst_resume: st=%0d rem=%0d, required 1/9", state, remain);
        end
    endtask

    task automatic test_ped();
        repeat (2) next_tick();
        n_checks++;
        if (remain !== 5'd7) begin
            n_fail++;
            $display("FAIL ped_setup: rem=%0d, required 7", remain);
        end
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        n_checks++;
        if (remain !== (PED_EN ? 5'd2 : 5'd7) || state !== 3'd1) begin
            n_fail++;
            $display("FAIL ped_shorten: rem=%0d st=%0d, required %0d/1",
                     remain, state, PED_EN ? 2 : 7);
        end
        repeat (2) next_tick();
        n_checks++;
        if (state !== (PED_EN ? 3'd2 : 3'd1) || remain !== (PED_EN ? 5'd3 : 5'd5)) begin
            n_fail++;
            $display("FAIL ped_short_green: st=%0d rem=%0d, required %0d/%0d",
                     state, remain, PED_EN ? 2 : 1, PED_EN ? 3 : 5);
        end
        until_state(3'd4);
        n_checks++;
        if (walk !== PED_EN || remain !== 5'd9) begin
            n_fail++;
            $display("FAIL walk_entry: walk=%b rem=%0d, required %b/9", walk, remain, PED_EN);
        end
        for (int k = 0; k < 8; k++) begin
            next_tick();
            n_checks++;
            if (walk !== PED_EN || state !== 3'd4) begin
                n_fail++;
                $display("FAIL walk_hold %0d: walk=%b st=%0d, required %b/4",
                         k, walk, state, PED_EN);
            end
        end
        next_tick();
        n_checks++;
        if (walk !== 1'b0 || state !== 3'd5) begin
            n_fail++;
            $display("FAIL walk_end: walk=%b st=%0d, required 0/5", walk, state);
        end
        until_state(3'd1);
        repeat (8) next_tick();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        n_checks++;
        if (remain !== 5'd1 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL ped_late: rem=%0d st=%0d, required 1/1", remain, state);
        end
        next_tick();
        n_checks++;
        if (state !== 3'd2 || remain !== 5'd3) begin
            n_fail++;
            $display("FAIL ped_late_timing: st=%0d rem=%0d, required 2/3", state, remain);
        end
        until_state(3'd4);
        n_checks++;
        if (walk !== PED_EN) begin
            n_fail++;
            $display("FAIL ped_late_walk: walk=%b, required %b", walk, PED_EN);
        end
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_night();
        test_reset_mid();
        test_ped();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
